chacha_cfg_regfile: RTL and testbench



---
 rtl/chacha_cfg_regfile.sv | 160 ++++++++++++++++
 tb/tb_chacha_cfg_regfile.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/chacha_cfg_regfile.sv
// Configuration/readback register file between the SPI slave byte stream and the ChaCha core.
// Single-byte commands select a key/nonce/position load or readback, a start pulse, or a status read.
module chacha_cfg_regfile #(
  parameter int KEY_BYTES   = 32,
  parameter int NONCE_BYTES = 12,
  parameter int POS_BYTES   = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_RX_DV,
  input  logic [7:0]               i_RX_Byte,
  output logic                     o_TX_DV,
  output logic [7:0]               o_TX_Byte,
  input  logic                     i_core_busy,
  output logic [8*KEY_BYTES-1:0]   o_key,
  output logic [8*NONCE_BYTES-1:0] o_nonce,
  output logic [8*POS_BYTES-1:0]   o_position,
  output logic                     o_start,
  output logic                     o_err
);

  localparam int MAX_BYTES =
    (KEY_BYTES > NONCE_BYTES) ? ((KEY_BYTES > POS_BYTES) ? KEY_BYTES : POS_BYTES)
                              : ((NONCE_BYTES > POS_BYTES) ? NONCE_BYTES : POS_BYTES);
  localparam int CW = $clog2(MAX_BYTES + 1);

  localparam logic [CW-1:0] KEY_LAST   = CW'(KEY_BYTES - 1);
  localparam logic [CW-1:0] NONCE_LAST = CW'(NONCE_BYTES - 1);
  localparam logic [CW-1:0] POS_LAST   = CW'(POS_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_KEY, WR_NONCE, WR_POS, RD_KEY, RD_NONCE, RD_POS, RD_STAT
  } state_e;

  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [8*KEY_BYTES-1:0]   key_q;
  logic [8*NONCE_BYTES-1:0] nonce_q;
  logic [8*POS_BYTES-1:0]   pos_q;
  logic                     tx_dv_q, start_q, err_q;
  logic [7:0]               tx_byte_q;
  logic                     lock_err_q, cmd_err_q;
  logic                     lock_err_d, cmd_err_d;

  logic [CW-1:0] cnt_nxt;
  logic          cnt_last;
  logic          is_wr;
  logic          idle_cmd;
  logic          lock_set, cmd_set, stat_clr;

  assign cnt_nxt  = cnt_q + CW'(1);
  assign is_wr    = (state_q == WR_KEY) || (state_q == WR_NONCE) || (state_q == WR_POS);
  assign idle_cmd = i_RX_DV && (state_q == IDLE);

  always_comb begin
    cnt_last = 1'b0;
    unique case (state_q)
      WR_KEY,   RD_KEY:   cnt_last = (cnt_q == KEY_LAST);
      WR_NONCE, RD_NONCE: cnt_last = (cnt_q == NONCE_LAST);
      WR_POS,   RD_POS:   cnt_last = (cnt_q == POS_LAST);
      default:            cnt_last = 1'b0;
    endcase
  end

  // A new error raised in the status-capture cycle overrides the clear.
  assign lock_set = i_RX_DV && i_core_busy &&
                    (is_wr || ((state_q == IDLE) && (i_RX_Byte == 8'h07)));
  assign cmd_set  = idle_cmd && ((i_RX_Byte == 8'h00) || (i_RX_Byte > 8'h08));
  assign stat_clr = idle_cmd && (i_RX_Byte == 8'h08);

  assign lock_err_d = (lock_err_q && !stat_clr) || lock_set;
  assign cmd_err_d  = (cmd_err_q  && !stat_clr) || cmd_set;

  // NOTE: every register here, including the key/nonce/position storage, uses
  // non-blocking assignments so all state updates see pre-edge values; the
  // storage is reset because its cleared value is architecturally visible.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      nonce_q    <= '0;
      pos_q      <= '0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      lock_err_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      tx_dv_q    <= 1'b0;
      start_q    <= 1'b0;
      lock_err_q <= lock_err_d;
      cmd_err_q  <= cmd_err_d;
      err_q      <= lock_err_q | cmd_err_q;

      if (i_RX_DV) begin
        unique case (state_q)
          IDLE: begin
            unique case (i_RX_Byte)
              8'h01: state_q <= WR_KEY;
              8'h02: state_q <= WR_NONCE;
              8'h03: state_q <= WR_POS;
              8'h04: begin
                state_q   <= RD_KEY;
                tx_dv_q   <= 1'b1;
                tx_byte_q <= key_q[7:0];
              end
              8'h05: begin
                state_q   <= RD_NONCE;
                tx_dv_q   <= 1'b1;
                tx_byte_q <= nonce_q[7:0];
              end
              8'h06: begin
                state_q   <= RD_POS;
                tx_dv_q   <= 1'b1;
                tx_byte_q <= pos_q[7:0];
              end
              8'h07: start_q <= !i_core_busy;
              8'h08: begin
                state_q   <= RD_STAT;
                tx_dv_q   <= 1'b1;
                tx_byte_q <= {5'b0, lock_err_q, cmd_err_q, i_core_busy};
              end
              default: ;
            endcase
          end
          WR_KEY:   if (!i_core_busy) key_q[{cnt_q, 3'b000} +: 8]   <= i_RX_Byte;
          WR_NONCE: if (!i_core_busy) nonce_q[{cnt_q, 3'b000} +: 8] <= i_RX_Byte;
          WR_POS:   if (!i_core_busy) pos_q[{cnt_q, 3'b000} +: 8]   <= i_RX_Byte;
          RD_KEY:   if (!cnt_last) tx_byte_q <= key_q[{cnt_nxt, 3'b000} +: 8];
          RD_NONCE: if (!cnt_last) tx_byte_q <= nonce_q[{cnt_nxt, 3'b000} +: 8];
          RD_POS:   if (!cnt_last) tx_byte_q <= pos_q[{cnt_nxt, 3'b000} +: 8];
          RD_STAT:  state_q <= IDLE;
          default:  state_q <= IDLE;
        endcase

        // Shared byte counting for every load and readback state.
        if ((state_q != IDLE) && (state_q != RD_STAT)) begin
          if (cnt_last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_nxt;
            if (!is_wr) tx_dv_q <= 1'b1;
          end
        end
      end
    end
  end

  assign o_key      = key_q;
  assign o_nonce    = nonce_q;
  assign o_position = pos_q;
  assign o_TX_DV    = tx_dv_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_start    = start_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_chacha_cfg_regfile.sv
// Directed bench for chacha_cfg_regfile: loads, readbacks, busy lockout, start, status and mid-transfer reset.
module tb_chacha_cfg_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rx_dv;
  logic [7:0]   rx_byte;
  logic         tx_dv;
  logic [7:0]   tx_byte;
  logic         busy;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  position;
  logic         start;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;
  int tx_pulses = 0;

  always #5 clk = ~clk;

  chacha_cfg_regfile dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .i_core_busy (busy),
    .o_key       (key),
    .o_nonce     (nonce),
    .o_position  (position),
    .o_start     (start),
    .o_err       (err)
  );

  always @(posedge clk) if (tx_dv === 1'b1) tx_pulses <= tx_pulses + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge, after the capturing rise.
  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  logic [255:0] exp_key;
  int           p0;

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_key", key, 256'h0);
    check("rst_nonce", nonce, 256'h0);
    check("rst_pos", position, 256'h0);
    check("rst_txdv", tx_dv, 256'h0);
    check("rst_txbyte", tx_byte, 256'h0);
    check("rst_start", start, 256'h0);
    check("rst_err", err, 256'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Key load 0x00..0x1F back-to-back, then full readback.
    send(8'h01);
    for (int i = 0; i < 32; i++) send(8'(i));
    for (int i = 0; i < 32; i++) exp_key[8*i +: 8] = 8'(i);
    check("key_load", key, exp_key);
    check("key_load_top", key[255:248], 256'h1F);
    p0 = tx_pulses;
    send(8'h04);
    check("rdkey_first_dv", tx_dv, 256'h1);
    check("rdkey_first_byte", tx_byte, 256'h00);
    for (int i = 0; i < 32; i++) begin
      send(8'hFF);
      if (i < 31) begin
        check("rdkey_dv", tx_dv, 256'h1);
        check("rdkey_byte", tx_byte, 256'(i + 1));
      end else begin
        check("rdkey_no33_dv", tx_dv, 256'h0);
        check("rdkey_hold_byte", tx_byte, 256'h1F);
      end
    end
    @(negedge clk);
    check("rdkey_pulse_count", 256'(tx_pulses - p0), 256'd32);

    // Position load and readback with a gap between bytes.
    send(8'h03);
    send(8'h78); @(negedge clk);
    send(8'h56); send(8'h34); send(8'h12);
    check("pos_load", position, 256'h12345678);
    send(8'h06);
    check("rdpos_first_dv", tx_dv, 256'h1);
    check("rdpos_first_byte", tx_byte, 256'h78);
    send(8'h00);
    check("rdpos_b1", tx_byte, 256'h56);
    send(8'h00);
    check("rdpos_b2", tx_byte, 256'h34);
    send(8'h00);
    check("rdpos_b3", tx_byte, 256'h12);
    check("rdpos_b3_dv", tx_dv, 256'h1);
    send(8'h00);
    check("rdpos_end_dv", tx_dv, 256'h0);

    // Nonce writes while busy are dropped and raise lock_err.
    busy = 1'b1;
    send(8'h02);
    for (int i = 0; i < 12; i++) send(8'hAA);
    check("nonce_locked", nonce, 256'h0);
    @(negedge clk);
    check("err_after_lock", err, 256'h1);
    send(8'h08);
    check("stat_busy_dv", tx_dv, 256'h1);
    check("stat_busy", tx_byte, 256'h05);
    send(8'h00);
    busy = 1'b0;
    send(8'h08);
    check("stat_cleared", tx_byte, 256'h00);
    send(8'h00);
    repeat (2) @(negedge clk);
    check("err_cleared", err, 256'h0);

    // Start pulse, then a start refused while busy.
    send(8'h07);
    check("start_pulse", start, 256'h1);
    @(negedge clk);
    check("start_one_cycle", start, 256'h0);
    busy = 1'b1;
    send(8'h07);
    check("start_blocked", start, 256'h0);
    busy = 1'b0;
    send(8'h08);
    check("stat_start_lock", tx_byte, 256'h04);
    send(8'h00);

    // Illegal command.
    send(8'h09);
    @(negedge clk);
    check("err_cmd", err, 256'h1);
    send(8'h08);
    check("stat_cmd_err", tx_byte, 256'h02);
    send(8'h00);

    // Reset in the middle of a key load.
    send(8'h01);
    for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i));
    check("key_partial", key[39:0], 256'hC4C3C2C1C0);
    rst_n = 1'b0;
    #1;
    check("midrst_key", key, 256'h0);
    check("midrst_err", err, 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h05);
    check("post_rst_rdnonce_dv", tx_dv, 256'h1);
    check("post_rst_rdnonce_byte", tx_byte, 256'h00);
    for (int i = 0; i < 12; i++) send(8'h00);
    check("post_rst_end_dv", tx_dv, 256'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
